// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell reused over WIDTH clocks, LSB first,
// with valid/ready request and response handshakes.
module serial_add_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid_i,
   output logic             start_ready_o,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   input  logic             cin_in_i,
   input  logic             sub_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [WIDTH-1:0] res_sum_o,
   output logic             res_cout_o,
   output logic             res_ovf_o,
   output logic             busy_o
);

   localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q;
   logic [WIDTH-1:0]  a_sh_q, b_sh_q, sum_sh_q, res_sum_q;
   logic [CntW-1:0]   cnt_q;
   logic              carry_q, msb_cin_q, res_cout_q;
   logic              s_d, c_d;
   logic [WIDTH-1:0]  sum_sh_d;

   // The single shared full-adder cell.
   always_comb begin
      s_d      = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
      c_d      = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
      sum_sh_d = {s_d, sum_sh_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         a_sh_q     <= '0;
         b_sh_q     <= '0;
         sum_sh_q   <= '0;
         res_sum_q  <= '0;
         cnt_q      <= '0;
         carry_q    <= 1'b0;
         msb_cin_q  <= 1'b0;
         res_cout_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_valid_i) begin
                  a_sh_q  <= op_a_i;
                  b_sh_q  <= sub_i ? ~op_b_i : op_b_i;
                  carry_q <= sub_i ? 1'b1 : cin_in_i;
                  cnt_q   <= '0;
                  state_q <= StRun;
               end
            end
            StRun: begin
               a_sh_q   <= a_sh_q >> 1;
               b_sh_q   <= b_sh_q >> 1;
               sum_sh_q <= sum_sh_d;
               carry_q  <= c_d;
               if (cnt_q == LastCnt) begin
                  msb_cin_q  <= carry_q;
                  res_sum_q  <= sum_sh_d;
                  res_cout_q <= c_d;
                  state_q    <= StDone;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StDone: begin
               if (res_ready_i) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign start_ready_o = (state_q == StIdle);
   assign busy_o        = (state_q != StIdle);
   assign res_valid_o   = (state_q == StDone);
   assign res_sum_o     = res_sum_q;
   assign res_cout_o    = res_cout_q;
   // Signed overflow: carry into the MSB differs from carry out of it.
   assign res_ovf_o     = msb_cin_q ^ res_cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus randomized jobs checked
// every cycle against a whole-word arithmetic model.
module tb_serial_add_ctrl;
   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_valid, start_ready, cin_in, sub, res_valid, res_ready;
   logic [W-1:0] op_a, op_b, res_sum;
   logic         res_cout, res_ovf, busy;

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_valid_i(start_valid),
      .start_ready_o(start_ready),
      .op_a_i       (op_a),
      .op_b_i       (op_b),
      .cin_in_i     (cin_in),
      .sub_i        (sub),
      .res_valid_o  (res_valid),
      .res_ready_i  (res_ready),
      .res_sum_o    (res_sum),
      .res_cout_o   (res_cout),
      .res_ovf_o    (res_ovf),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Whole-word reference: {ovf, cout, sum}.
   function automatic logic [W+1:0] ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic s);
      logic [W-1:0] bb;
      logic [W:0]   full;
      logic         ovf;
      bb   = s ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : cin)};
      ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
      return {ovf, full[W], full[W-1:0]};
   endfunction

   // Behavioural model: idle / counting down / result pending.
   logic         m_idle, m_valid;
   int           m_left;
   logic [W+1:0] m_pend, m_exp;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_idle  <= 1'b1;
         m_valid <= 1'b0;
         m_left  <= 0;
         m_pend  <= '0;
         m_exp   <= '0;
      end else if (m_valid) begin
         if (res_ready) begin
            m_valid <= 1'b0;
            m_idle  <= 1'b1;
         end
      end else if (!m_idle) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_valid <= 1'b1;
            m_exp   <= m_pend;
         end
      end else if (start_valid) begin
         m_pend <= ref_calc(op_a, op_b, cin_in, sub);
         m_idle <= 1'b0;
         m_left <= W;
      end
   end

   always @(negedge clk) begin
      if (started && rst_n) begin
         chk("start_ready", start_ready, m_idle);
         chk("busy", busy, !m_idle);
         chk("res_valid", res_valid, m_valid);
         if (m_valid || m_idle) begin
            chk("res_sum", res_sum, m_exp[W-1:0]);
            chk("res_cout", res_cout, m_exp[W]);
            chk("res_ovf", res_ovf, m_exp[W+1]);
         end
      end
   end

   // Issue a job, measure latency, optionally check literal results, then handshake.
   task automatic do_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, input bit lit, input logic [W-1:0] es,
                         input logic ec, input logic eo, input int rdy_delay);
      int n;
      int i;
      @(negedge clk);
      op_a = a; op_b = b; cin_in = c; sub = s; start_valid = 1'b1;
      for (i = 0; i < 50; i++) begin
         if (start_ready) break;
         @(negedge clk);
      end
      if (i == 50) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1 start_valid = 1'b0;
      op_a = W'($urandom); op_b = W'($urandom); cin_in = 1'($urandom); sub = 1'($urandom);
      for (n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (res_valid) break;
      end
      if (lit) begin
         chk("latency", n, W);
         chk("lit_sum", res_sum, es);
         chk("lit_cout", res_cout, ec);
         chk("lit_ovf", res_ovf, eo);
      end else if (n > 20) begin
         chk("result_timeout", 0, 1);
      end
      repeat (rdy_delay) @(posedge clk);
      #1 res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
   endtask

   initial begin
      int n;
      rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
      op_a = '0; op_b = '0; cin_in = 1'b0; sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_start_ready", start_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_sum", res_sum, 0);
      chk("rst_cout_ovf", {res_cout, res_ovf}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      started = 1'b1;

      do_job(8'h5A, 8'h3C, 1'b0, 1'b0, 1, 8'h96, 1'b0, 1'b1, 0);
      do_job(8'hFF, 8'h01, 1'b0, 1'b0, 1, 8'h00, 1'b1, 1'b0, 1);
      do_job(8'h7F, 8'h00, 1'b1, 1'b0, 1, 8'h80, 1'b0, 1'b1, 0);
      do_job(8'h10, 8'h20, 1'b1, 1'b1, 1, 8'hF0, 1'b0, 1'b0, 2);
      do_job(8'h80, 8'h01, 1'b0, 1'b1, 1, 8'h7F, 1'b1, 1'b1, 0);

      // Back-pressure with a pending request and changing operands.
      @(negedge clk);
      op_a = 8'h12; op_b = 8'h34; cin_in = 1'b0; sub = 1'b0; start_valid = 1'b1;
      @(posedge clk);
      for (n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (res_valid) break;
      end
      chk("bp_latency", n, W);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1 op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
         cin_in = 1'($urandom);
         chk("bp_valid", res_valid, 1);
         chk("bp_start_ready", start_ready, 0);
         chk("bp_sum", res_sum, 8'h46);
      end
      op_a = 8'h33; op_b = 8'h11; cin_in = 1'b0; sub = 1'b0; res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      chk("bp_idle_after", start_ready, 1);
      @(posedge clk);
      #1 start_valid = 1'b0;
      chk("bp_accepted", busy, 1);
      for (n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (res_valid) break;
      end
      chk("bp2_latency", n, W);
      chk("bp2_sum", res_sum, 8'h44);
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;

      // Reset during the third RUN cycle.
      @(negedge clk);
      op_a = 8'hAA; op_b = 8'h55; sub = 1'b0; cin_in = 1'b1; start_valid = 1'b1;
      @(posedge clk);
      #1 start_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_ready", start_ready, 1);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_valid", res_valid, 0);
      chk("async_rst_sum", res_sum, 0);
      chk("async_rst_cout_ovf", {res_cout, res_ovf}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("no_valid_after_rst", res_valid, 0);
      end
      do_job(8'h01, 8'h02, 1'b0, 1'b0, 1, 8'h03, 1'b0, 1'b0, 0);

      // Randomized jobs; the per-cycle model comparison does the checking.
      for (int j = 0; j < 60; j++) begin
         do_job(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0, '0, 1'b0, 1'b0,
                int'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder/subtractor controller. It time-multiplexes a single one-bit full-adder cell across a WIDTH-bit operand pair, one bit per clock, LSB first. It holds the carry between bits, accepts jobs over a valid/ready request port, and returns the result over a valid/ready response port. It sits between an operand source and a result consumer wherever area matters more than throughput.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  request valid.
- start_ready  out  1  controller can accept a request.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- cin_in  in  1  carry-in for add mode; ignored when sub=1.
- sub  in  1  1 = compute op_a − op_b; 0 = compute op_a + op_b + cin_in.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- res_sum  out  WIDTH  result bits.
- res_cout  out  1  carry out of the MSB. In sub mode, 1 means no borrow.
- res_ovf  out  1  signed (two's-complement) overflow.
- busy  out  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - start_ready=1.
  - On start_valid && start_ready:
    - a_sh ← op_a.
    - b_sh ← sub ? ~op_b : op_b.
    - carry ← sub ? 1 : cin_in.
    - cnt ← 0.
    - Go to RUN.
- RUN, once per cycle:
  - s = a_sh[0] ^ b_sh[0] ^ carry.
  - c' = majority(a_sh[0], b_sh[0], carry).
  - a_sh and b_sh shift right by 1.
  - sum_sh ← {s, sum_sh[WIDTH-1:1]}.
  - carry ← c'.
  - cnt ← cnt+1.
  - On the step where cnt==WIDTH-1:
    - Latch msb_cin ← carry (the carry into the MSB).
    - Go to DONE with res_sum ← final sum_sh, res_cout ← c', res_ovf ← carry ^ c'.
- DONE
  - res_valid=1.
  - res_sum, res_cout and res_ovf are held stable.
  - On res_ready, go to IDLE.
  - start_ready=0, so no new request is accepted on the same edge as the response handshake.
- Arithmetic is modulo 2^WIDTH. The carry register is exactly 1 bit. cnt is ceil(log2(WIDTH)) bits and never wraps inside a job.
- Request inputs are sampled only on the accept edge. Changes to them during RUN or DONE have no effect.
- start_valid while start_ready=0 is ignored; the requester must hold it.
- res_sum, res_cout and res_ovf keep their last values in IDLE. They are meaningful only while res_valid=1.

## Timing
- Reset (async assert, sync deassert handled upstream) puts the block in IDLE:
  - start_ready=1, res_valid=0, busy=0.
  - res_sum=0, res_cout=0, res_ovf=0.
  - Internal registers cleared.
- Reset asserted in any state aborts the job immediately. The result is never delivered.
- Latency: request accepted at edge E0 → res_valid visible after edge E0+WIDTH (exactly WIDTH cycles).
- With res_ready held 1, the response handshake is at E0+WIDTH+1. start_ready rises after that edge. Minimum spacing between accepts is WIDTH+2 cycles.
- Back-pressure: res_valid stays high, and outputs stay bit-stable, for any number of cycles until res_ready=1.
- busy = (state != IDLE) = ~start_ready.

## Test plan
All scenarios use WIDTH=8.
- Add with signed overflow: a=0x5A, b=0x3C, cin=0, sub=0 → res_sum=0x96, res_cout=0, res_ovf=1. res_valid rises exactly 8 cycles after the accept edge.
- Unsigned wrap: a=0xFF, b=0x01, cin=0 → res_sum=0x00, res_cout=1, res_ovf=0.
- Carry-in into the sign bit: a=0x7F, b=0x00, cin=1 → res_sum=0x80, res_cout=0, res_ovf=1.
- Subtract with borrow: a=0x10, b=0x20, sub=1, cin_in=1 (must be ignored) → res_sum=0xF0, res_cout=0, res_ovf=0. Also a=0x80, b=0x01, sub=1 → res_sum=0x7F, res_cout=1, res_ovf=1.
- Back-pressure: hold res_ready=0 for 20 cycles with start_valid=1 and changing operands.
  - res_valid and outputs stay constant; start_ready=0 throughout.
  - When res_ready is raised, state is IDLE next cycle and the pending request is accepted on the following edge.
  - The second result matches the operands present at that accept edge.
- Reset mid-job: pull rst_n low during the 3rd RUN cycle.
  - All outputs go to reset values without waiting for a clock edge.
  - No res_valid appears afterwards.
  - After release, a=0x01, b=0x02 → res_sum=0x03, res_cout=0, res_ovf=0.
